uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- 8N1 UART transmitter. It is the return path for the board's serial link, sending status and echo bytes back to the host.
- Sits beside the existing UART receiver in the top level, on the same clock.
- A small byte FIFO decouples the producer (game/GPU control logic) from the serial rate.
- Frames are sent back-to-back while the FIFO holds data.

Parameters:
- CLKS_PER_BIT, 218, clock cycles per serial bit (25.175 MHz / 115200); must be >= 2.
- FIFO_DEPTH, 4, byte entries; power of two, >= 2.
- STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tx_data  in  8  byte to enqueue
- tx_wr  in  1  enqueue strobe, one byte per asserted cycle
- tx_full  out  1  FIFO full (registered)
- tx_idle  out  1  FIFO empty and no frame in progress
- tx_ovf_tick  out  1  one-cycle pulse: write dropped because FIFO was full
- tx_done_tick  out  1  one-cycle pulse on the last cycle of the final stop bit
- tx  out  1  serial line, idle high

Behaviour:
- Reset: clock is clk; reset is synchronous and active-high. Reset forces:
  - tx=1, tx_full=0, tx_idle=1, tx_ovf_tick=0, tx_done_tick=0.
  - FIFO pointers and count=0, state=IDLE, bit counter and baud counter=0.
  - Reset mid-frame aborts the frame immediately: tx returns high on the next cycle and FIFO contents are discarded.
- Write:
  - With tx_wr=1 and tx_full=0 at an edge, tx_data is stored and count increments.
  - With tx_wr=1 and tx_full=1, the byte is dropped and tx_ovf_tick pulses next cycle. This holds even if a pop occurs in the same cycle.
- State machine IDLE -> START -> DATA -> (PARITY) -> STOP -> IDLE/START:
  - IDLE: tx=1. If count!=0: pop the head byte into the shift register, clear the baud counter, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles; shift right on each bit boundary.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. tx_done_tick=1 on the final cycle.
  - At end of STOP: if count!=0, pop and enter START directly, with zero idle cycles between frames. Otherwise go to IDLE.
- Latency: write at edge N into an empty, idle block -> IDLE pops at edge N+1 -> tx is low from edge N+2.
- Frame length: (1+8+STOP_BITS)*CLKS_PER_BIT cycles, exact. The baud counter runs 0..CLKS_PER_BIT-1 and wraps.
- Same-cycle write and pop: both take effect and count is unchanged. The pointers wrap modulo FIFO_DEPTH.
- tx is driven from a flop (glitch-free).
- tx_idle = (state==IDLE) & (count==0), registered.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state follows DATA. tx = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles. Frame is 8E1/8E2.
- Undefined: no PARITY state and no parity logic synthesised. Frame is 8N1/8N2.

Decomposition:
- Package uart_pkg holds:
  - The tx state enum (IDLE, START, DATA, PARITY, STOP).
  - DATA_BITS=8.
  - The default CLKS_PER_BIT value, shared with the receiver so both ends agree on the baud rate.
- Sub-module uart_tx_fifo_mem: synchronous FIFO with wr, rd, din, dout, full, empty and count. The top holds the FSM, the baud counter and the shift register.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4, STOP_BITS=1):
- Reset then idle 50 cycles -> tx=1 throughout, tx_idle=1, no ticks.
- Write 0x41 once -> tx low from the 2nd edge after the write. Line carries 0,1,0,0,0,0,0,1,0,1, each bit 4 cycles (40 cycles total). tx_done_tick on cycle 40. tx_idle=1 after.
- Write 0x55, 0xAA, 0x0F, 0xF0 on consecutive cycles -> four frames with no gap (160 cycles). tx_full never asserts, because the first pop frees a slot. Bytes arrive in order.
- Write 6 bytes on consecutive cycles -> tx_full asserts. Exactly one tx_ovf_tick for the 6th byte. Five frames transmitted.
- Assert reset at cycle 15 of a 0x41 frame -> tx=1 next cycle, tx_idle=1, a previously queued byte is never sent.
- With UART_TX_PARITY_EN, write 0x41 then 0x07 -> parity bits are 0 then 1. Frames are 44 cycles each.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the board's serial link (transmitter and receiver).
//   DATA_BITS             - payload bits per frame
//   CLKS_PER_BIT_DEFAULT  - 25.175 MHz / 115200 baud; the receiver uses the same
//                           value so both ends of the link agree on bit timing
//   tx_state_t            - transmitter state encoding
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int CLKS_PER_BIT_DEFAULT = 218;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_if
// Producer-side bundle of the UART transmitter.
//   tx_data      producer -> tx  byte to enqueue
//   tx_wr        producer -> tx  enqueue strobe, one byte per asserted cycle
//   tx_full      tx -> producer  FIFO full (registered)
//   tx_idle      tx -> producer  FIFO empty and no frame in progress
//   tx_ovf_tick  tx -> producer  pulse: a write was dropped (FIFO full)
//   tx_done_tick tx -> producer  pulse on the last cycle of the final stop bit
//   tx           tx -> line      serial output, idle high
//   state_dbg    tx -> observer  current transmitter FSM state
// Handshake: there is no backpressure wait. A byte is accepted on every edge
// where tx_wr=1 and tx_full=0; with tx_full=1 the byte is lost and
// tx_ovf_tick reports it in the following cycle.
// -----------------------------------------------------------------------------
interface uart_tx_fifo_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_wr;
  logic                 tx_full;
  logic                 tx_idle;
  logic                 tx_ovf_tick;
  logic                 tx_done_tick;
  logic                 tx;
  tx_state_t            state_dbg;

  modport master (
    output tx_data, tx_wr,
    input  tx_full, tx_idle, tx_ovf_tick, tx_done_tick, tx, state_dbg
  );

  modport slave (
    input  tx_data, tx_wr,
    output tx_full, tx_idle, tx_ovf_tick, tx_done_tick, tx, state_dbg
  );

endinterface

// File: rtl/uart_tx_fifo_mem.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_mem
// Synchronous show-ahead FIFO: dout always presents the head entry, so a pop
// and the consumer's capture of dout happen on the same edge.
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   wr, din     write strobe and data; ignored while full
//   rd          pop strobe; ignored while empty
//   dout        head entry
//   full, empty registered status flags
//   count       number of stored entries
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module uart_tx_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr,
  input  logic                     rd,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_next;
  logic             wr_en;
  logic             rd_en;

  // A write while full is dropped even if a pop frees a slot on the same edge.
  assign wr_en = wr && !full;
  assign rd_en = rd && !empty;
  assign dout  = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (wr_en && !rd_en) count_next = count + (AW+1)'(1);
    if (rd_en && !wr_en) count_next = count - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      full  <= (count_next == (AW+1)'(DEPTH));
      empty <= (count_next == '0);
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// UART transmitter with a small byte FIFO: the return path of the board's
// serial link (status and echo bytes back to the host). Frames are sent
// back-to-back while the FIFO holds data.
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (>= 2)
//   FIFO_DEPTH    byte entries (power of two, >= 2)
//   STOP_BITS     1 or 2
// Ports:
//   clk, reset    system clock, synchronous active-high reset
//   bus           uart_tx_fifo_if.slave (tx_data, tx_wr, tx_full, tx_idle,
//                 tx_ovf_tick, tx_done_tick, tx, state_dbg)
// Build option:
//   UART_TX_PARITY_EN  when defined, an even-parity bit follows the data bits
//                      (8E1/8E2); otherwise frames are 8N1/8N2.
// Timing: every line-level output is a flop fed from the current state, so tx
// lags the FSM by one cycle. A write at edge N into an idle block is popped at
// N+1 and the start bit appears on tx from N+2. Frame length is exactly
// (1 + 8 [+1] + STOP_BITS) * CLKS_PER_BIT cycles with no gap between frames.
// -----------------------------------------------------------------------------
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int FIFO_DEPTH   = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic          clk,
  input  logic          reset,
  uart_tx_fifo_if.slave bus
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_t            state;
  logic [BW-1:0]        baud;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 tx_r;
  logic                 idle_r;
  logic                 ovf_r;
  logic                 done_r;
`ifdef UART_TX_PARITY_EN
  logic                 parity_r;
`endif

  logic [DATA_BITS-1:0] fifo_dout;
  logic [CW-1:0]        fifo_count;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 pop;
  logic                 baud_last;
  logic                 last_stop;

  assign baud_last = (baud == BW'(CLKS_PER_BIT - 1));
  assign last_stop = (bit_cnt == 3'(STOP_BITS - 1));

  // Pop from IDLE, or at the very end of the stop period so the next start
  // bit follows with no idle cycles.
  assign pop = !fifo_empty &&
               ((state == IDLE) || (state == STOP && baud_last && last_stop));

  uart_tx_fifo_mem #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .wr    (bus.tx_wr),
    .rd    (pop),
    .din   (bus.tx_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      tx_r    <= 1'b1;
      idle_r  <= 1'b1;
      ovf_r   <= 1'b0;
      done_r  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_r <= 1'b0;
`endif
    end else begin
      ovf_r  <= bus.tx_wr && fifo_full;
      idle_r <= (state == IDLE) && (fifo_count == '0);
      done_r <= 1'b0;

      case (state)
        IDLE: begin
          tx_r <= 1'b1;
          if (pop) begin
            shreg   <= fifo_dout;
            baud    <= '0;
            bit_cnt <= '0;
            state   <= START;
`ifdef UART_TX_PARITY_EN
            parity_r <= ^fifo_dout;
`endif
          end
        end

        START: begin
          tx_r <= 1'b0;
          if (baud_last) begin
            baud    <= '0;
            bit_cnt <= '0;
            state   <= DATA;
          end else begin
            baud <= baud + BW'(1);
          end
        end

        DATA: begin
          tx_r <= shreg[0];
          if (baud_last) begin
            baud  <= '0;
            shreg <= {1'b0, shreg[DATA_BITS-1:1]};
            if (bit_cnt == 3'(DATA_BITS - 1)) begin
              bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              state   <= PARITY;
`else
              state   <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          tx_r <= parity_r;
          if (baud_last) begin
            baud    <= '0;
            bit_cnt <= '0;
            state   <= STOP;
          end else begin
            baud <= baud + BW'(1);
          end
        end
`endif

        STOP: begin
          tx_r <= 1'b1;
          if (baud_last) begin
            baud <= '0;
            if (last_stop) begin
              // Registered alongside tx, so the pulse lines up with the last
              // stop-bit cycle actually on the line.
              done_r  <= 1'b1;
              bit_cnt <= '0;
              if (pop) begin
                shreg <= fifo_dout;
                state <= START;
`ifdef UART_TX_PARITY_EN
                parity_r <= ^fifo_dout;
`endif
              end else begin
                state <= IDLE;
              end
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end

        default: begin
          tx_r  <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.tx           = tx_r;
  assign bus.tx_full      = fifo_full;
  assign bus.tx_idle      = idle_r;
  assign bus.tx_ovf_tick  = ovf_r;
  assign bus.tx_done_tick = done_r;
  assign bus.state_dbg    = state;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
// Directed bench for uart_tx_fifo with CLKS_PER_BIT=4, FIFO_DEPTH=4,
// STOP_BITS=1. Line outputs are logged every cycle on the falling edge
// (index = number of rising edges so far) and checked at hand-computed cycle
// offsets. A serial receiver model decodes every frame on tx and compares it
// against the expected byte queue.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int CPB = 4;
  localparam int LOG = 2048;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 44;
  // line bits for 0x41, bit 0 first: start, 1,0,0,0,0,0,1,0, parity 0, stop
  localparam logic [10:0] FRAME_41 = 11'b100_1000_0010;
`else
  localparam int FRAME = 40;
  // line bits for 0x41, bit 0 first: start, 1,0,0,0,0,0,1,0, stop
  localparam logic [10:0] FRAME_41 = 11'b010_1000_0010;
`endif

  // clock / reset
  logic clk;
  logic reset;
  int   cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  uart_tx_fifo_if bus ();

  uart_tx_fifo #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4),
    .STOP_BITS    (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // per-cycle logs
  logic tx_log   [LOG];
  logic full_log [LOG];
  logic idle_log [LOG];
  logic ovf_log  [LOG];
  logic done_log [LOG];

  always @(negedge clk) begin
    if (cyc < LOG) begin
      tx_log[cyc]   = bus.tx;
      full_log[cyc] = bus.tx_full;
      idle_log[cyc] = bus.tx_idle;
      ovf_log[cyc]  = bus.tx_ovf_tick;
      done_log[cyc] = bus.tx_done_tick;
    end
  end

  function automatic int cnt_val(input logic a [LOG], input logic v,
                                 input int lo, input int hi);
    int n;
    n = 0;
    for (int i = lo; i <= hi; i++) if (a[i] === v) n++;
    return n;
  endfunction

  // scoreboard
  logic [7:0] exp_q [$];
  int n_checks;
  int n_bad;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // driver tasks
  task automatic wr_byte(input logic [7:0] d, input logic accept,
                         output int edge_n);
    @(negedge clk);
    bus.tx_wr   = 1'b1;
    bus.tx_data = d;
    edge_n      = cyc + 1;
    if (accept) exp_q.push_back(d);
  endtask

  task automatic wr_end();
    @(negedge clk);
    bus.tx_wr   = 1'b0;
    bus.tx_data = 8'h00;
  endtask

  // serial receiver model
  logic       mon_en;
  logic       r_act;
  logic [7:0] r_byte;
  logic [7:0] r_exp;
  logic       r_stop;
`ifdef UART_TX_PARITY_EN
  logic       r_par;
`endif

  initial begin : rx_monitor
    forever begin
      @(negedge clk);
      if (bus.tx === 1'b0 && reset === 1'b0) begin
        r_act = mon_en;
        repeat (CPB + 1) @(negedge clk);
        r_byte[0] = bus.tx;
        for (int k = 1; k < 8; k++) begin
          repeat (CPB) @(negedge clk);
          r_byte[k] = bus.tx;
        end
`ifdef UART_TX_PARITY_EN
        repeat (CPB) @(negedge clk);
        r_par = bus.tx;
`endif
        repeat (CPB) @(negedge clk);
        r_stop = bus.tx;
        if (r_act) begin
          check("rx_stop", r_stop, 1'b1);
          check("rx_expected_frame", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            r_exp = exp_q.pop_front();
            check("rx_byte", r_byte, r_exp);
`ifdef UART_TX_PARITY_EN
            check("rx_parity", r_par, ^r_exp);
`endif
          end
        end
      end
    end
  end

  // stimulus
  logic [10:0] f41;
  logic [7:0]  burst4 [4];
  logic [7:0]  burst6 [6];
  int n0;
  int nx;

  initial begin
    cyc         = 0;
    n_checks    = 0;
    n_bad       = 0;
    mon_en      = 1'b1;
    reset       = 1'b1;
    bus.tx_wr   = 1'b0;
    bus.tx_data = 8'h00;
    f41         = FRAME_41;
    burst4      = '{8'h55, 8'hAA, 8'h0F, 8'hF0};
    burst6      = '{8'h01, 8'h80, 8'h3C, 8'hC3, 8'h99, 8'h77};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_tx", bus.tx, 1'b1);
    check("rst_full", bus.tx_full, 1'b0);
    check("rst_idle", bus.tx_idle, 1'b1);
    check("rst_ovf", bus.tx_ovf_tick, 1'b0);
    check("rst_done", bus.tx_done_tick, 1'b0);
    check("rst_state", bus.state_dbg, IDLE);
    reset = 1'b0;

    // idle for 50 cycles
    n0 = cyc;
    repeat (52) @(negedge clk);
    check("idle_tx_low", cnt_val(tx_log, 1'b0, n0 + 1, n0 + 50), 0);
    check("idle_idle_low", cnt_val(idle_log, 1'b0, n0 + 1, n0 + 50), 0);
    check("idle_ovf", cnt_val(ovf_log, 1'b1, n0 + 1, n0 + 50), 0);
    check("idle_done", cnt_val(done_log, 1'b1, n0 + 1, n0 + 50), 0);

    // single byte 0x41
    wr_byte(8'h41, 1'b1, n0);
    wr_end();
    repeat (FRAME + 10) @(negedge clk);
    check("one_pre_start", tx_log[n0 + 1], 1'b1);
    for (int i = 0; i < FRAME; i++)
      check("one_line_bit", tx_log[n0 + 2 + i], f41[i / CPB]);
    check("one_after", tx_log[n0 + 2 + FRAME], 1'b1);
    check("one_done_pos", done_log[n0 + 1 + FRAME], 1'b1);
    check("one_done_cnt", cnt_val(done_log, 1'b1, n0, n0 + FRAME + 8), 1);
    check("one_idle_after", idle_log[n0 + FRAME + 3], 1'b1);

    // four back-to-back bytes, FIFO never fills
    wr_byte(burst4[0], 1'b1, n0);
    for (int i = 1; i < 4; i++) wr_byte(burst4[i], 1'b1, nx);
    wr_end();
    repeat (4 * FRAME + 12) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check("b4_stop_before", tx_log[n0 + 1 + FRAME * k], 1'b1);
      check("b4_start", tx_log[n0 + 2 + FRAME * k], 1'b0);
      check("b4_done_pos", done_log[n0 + 1 + FRAME * (k + 1)], 1'b1);
    end
    check("b4_full_never", cnt_val(full_log, 1'b1, n0, n0 + 4 * FRAME + 8), 0);
    check("b4_done_cnt", cnt_val(done_log, 1'b1, n0, n0 + 4 * FRAME + 8), 4);
    check("b4_ovf", cnt_val(ovf_log, 1'b1, n0, n0 + 4 * FRAME + 8), 0);

    // six back-to-back bytes, the sixth overflows
    wr_byte(burst6[0], 1'b1, n0);
    for (int i = 1; i < 6; i++) wr_byte(burst6[i], i < 5, nx);
    wr_end();
    repeat (5 * FRAME + 12) @(negedge clk);
    check("b6_full_before", full_log[n0 + 3], 1'b0);
    check("b6_full_set", full_log[n0 + 4], 1'b1);
    check("b6_ovf_pos", ovf_log[n0 + 5], 1'b1);
    check("b6_ovf_cnt", cnt_val(ovf_log, 1'b1, n0, n0 + 5 * FRAME + 8), 1);
    check("b6_done_cnt", cnt_val(done_log, 1'b1, n0, n0 + 5 * FRAME + 8), 5);

    // reset at cycle 15 of a frame, with a second byte queued
    mon_en = 1'b0;
    wr_byte(8'h41, 1'b0, n0);
    wr_byte(8'h22, 1'b0, nx);
    wr_end();
    for (int g = 0; g < 100 && cyc < n0 + 15; g++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (70) @(negedge clk);
    check("rst_mid_bit2", tx_log[n0 + 15], 1'b0);
    check("rst_mid_tx", tx_log[n0 + 16], 1'b1);
    check("rst_mid_idle", idle_log[n0 + 16], 1'b1);
    check("rst_mid_quiet", cnt_val(tx_log, 1'b0, n0 + 16, n0 + 80), 0);
    check("rst_mid_done", cnt_val(done_log, 1'b1, n0 + 16, n0 + 80), 0);
    mon_en = 1'b1;

`ifdef UART_TX_PARITY_EN
    // parity bits for 0x41 (0) and 0x07 (1)
    wr_byte(8'h41, 1'b1, n0);
    wr_byte(8'h07, 1'b1, nx);
    wr_end();
    repeat (2 * FRAME + 12) @(negedge clk);
    check("par_41", tx_log[n0 + 2 + 36], 1'b0);
    check("par_07", tx_log[n0 + 2 + FRAME + 36], 1'b1);
    check("par_done1", done_log[n0 + 1 + FRAME], 1'b1);
    check("par_done2", done_log[n0 + 1 + 2 * FRAME], 1'b1);
`endif

    repeat (10) @(negedge clk);
    check("rx_leftover", exp_q.size(), 0);
    check("end_idle", bus.tx_idle, 1'b1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
